rv32_fetch_stage: RTL
=====================

RV32_FETCH_STAGE -- requirements
Module: rv32_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports, in this order:
  clk  input  1  clock
  rst  input  1  synchronous active-high reset
  redirect_valid  input  1  taken branch/jump from the branch unit (its took output)
  redirect_target  input  32  new PC from the branch unit (its target output)
  imem_req_valid  output  1  fetch request
  imem_req_ready  input  1  memory accepts request
  imem_req_addr  output  32  word-aligned fetch address
  imem_rsp_valid  input  1  instruction returned, one per accepted request, latency >= 1 cycle
  imem_rsp_data  input  32  instruction word
  if_valid  output  1  instruction available to decode
  if_ready  input  1  decode consumes
  if_pc  output  32  PC of presented instruction
  if_instr  output  32  presented instruction
  if_fault  output  1  instruction-address-misaligned marker

Function
REQ-004 SHALL keep at most one accepted-but-unanswered memory request at any time.
REQ-005 SHALL use FSM states S_REQ (drive request), S_WAIT (await response), S_FAULT (halted on misaligned target).
REQ-006 S_REQ: assert imem_req_valid when buffer count + outstanding < 2; on valid&&ready go to S_WAIT and set pc = pc+4 (mod 2^32).
REQ-007 Once asserted, imem_req_valid and imem_req_addr SHALL hold stable until imem_req_ready, even across redirect.
REQ-008 S_WAIT: on imem_rsp_valid push {pc_of_request, data, fault=0} into buffer, return to S_REQ.
REQ-009 SHALL buffer fetched instructions in a 2-entry FIFO; if_* presents the head; pop on if_valid && if_ready.
REQ-010 if_* SHALL remain stable while if_valid && !if_ready.
REQ-011 Redirect SHALL have priority over every other event in the same cycle: flush the FIFO, load pc = redirect_target, drive the first new request no earlier than the next cycle.
REQ-012 Redirect while a request is outstanding or pending-unaccepted SHALL set drop_pending; the matching response is discarded and clears drop_pending.
REQ-013 Redirect in the same cycle as imem_rsp_valid SHALL discard that response and leave drop_pending clear.
REQ-014 Requests to the new PC SHALL issue only when drop_pending is clear, so one outstanding request is preserved.
REQ-015 Redirect with redirect_target[1:0] != 0 SHALL enter S_FAULT: push one entry {pc=target, instr=32'h0000_0013, fault=1}; no further requests until the next redirect.
REQ-016 A pop and a push in the same cycle on a full FIFO SHALL both take effect.
REQ-017 Redirect and pop in the same cycle: the popped entry is consumed, all other entries flushed.
REQ-018 imem_req_addr[1:0] SHALL always be 2'b00.

Reset
REQ-019 During rst: pc=RESET_PC, state S_REQ, FIFO empty, drop_pending=0, imem_req_valid=0, if_valid=0, if_fault=0, if_pc=0, if_instr=0.
REQ-020 First request (addr RESET_PC) SHALL be driven in the first cycle after rst deasserts.
REQ-021 Reset mid-operation SHALL abandon any outstanding request; responses after reset are ignored until a new request is accepted.

Structure
REQ-022 FSM state enum, NOP constant 32'h0000_0013 and FIFO depth SHALL live in the shared rv32 package.
REQ-023 The 2-entry FIFO SHALL be one sub-module, rv32_fetch_buf; pc/FSM/drop logic lives in the top.

Verification
REQ-024 Reset, ready=1, rsp latency 1, if_ready=1 -> addresses 0,4,8,12 in order; if_pc matches each; no gaps beyond one per two cycles.
REQ-025 if_ready=0 for 10 cycles -> exactly two entries buffered, imem_req_valid low, if_* stable; release -> PCs 0,4 then 8 fetched.
REQ-026 Redirect target 32'h100 while request to 8 outstanding -> response for 8 dropped, next if_pc = 32'h100, never 8.
REQ-027 Redirect same cycle as rsp_valid -> response dropped, request to target issued next cycle, drop_pending stays 0.
REQ-028 Redirect target 32'h202 -> one if_valid with if_fault=1, if_pc=32'h202, if_instr=32'h13; no requests until redirect to 32'h300.
REQ-029 PC 32'hFFFF_FFFC fetched -> next request address 32'h0000_0000.

Source files
------------

// File: rtl/rv32_fetch_stage_pkg.sv
// Shared RV32 fetch definitions: FSM encoding, buffer geometry, NOP word and buffer entry type.
package rv32_fetch_stage_pkg;

  localparam int unsigned FETCH_BUF_DEPTH = 2;
  localparam int unsigned FETCH_CNT_W     = $clog2(FETCH_BUF_DEPTH + 1);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t S_REQ   = 2'd0;
  localparam fetch_state_t S_WAIT  = 2'd1;
  localparam fetch_state_t S_FAULT = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/rv32_fetch_stage_if.sv
// Bundle of the fetch stage's memory-side and decode-side handshake signals.
interface rv32_fetch_stage_if;

  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;

  // Fetch-stage side.
  modport master (
    input  redirect_valid, redirect_target, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  if_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, if_fault
  );

  // Memory / branch unit / decode side.
  modport slave (
    output redirect_valid, redirect_target, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output if_ready,
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, if_fault
  );

endinterface

// File: rtl/rv32_fetch_buf.sv
// Small circular FIFO of fetched instructions; flush empties it but may accept a push that cycle.
module rv32_fetch_buf
  import rv32_fetch_stage_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output fetch_entry_t           head_o,
  output logic [FETCH_CNT_W-1:0] count_o
);

  localparam int unsigned PtrW = (FETCH_BUF_DEPTH > 1) ? $clog2(FETCH_BUF_DEPTH) : 1;

  fetch_entry_t           mem_q [FETCH_BUF_DEPTH];
  logic [PtrW-1:0]        rd_q, rd_d, wr_q, wr_d, wr_idx;
  logic [FETCH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   do_pop, do_push, wr_en;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FETCH_BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i && (cnt_q != '0);
  // A push into a full buffer is accepted when a pop frees the head in the same cycle.
  assign do_push = push_i && ((32'(cnt_q) < FETCH_BUF_DEPTH) || do_pop);

  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = wr_q;
    if (flush_i) begin
      rd_d   = '0;
      wr_idx = '0;
      wr_en  = push_i;
      wr_d   = push_i ? ptr_inc('0) : '0;
      cnt_d  = push_i ? FETCH_CNT_W'(1) : '0;
    end else begin
      if (do_push) begin
        wr_en = 1'b1;
        wr_d  = ptr_inc(wr_q);
      end
      if (do_pop) begin
        rd_d = ptr_inc(rd_q);
      end
      cnt_d = cnt_q + FETCH_CNT_W'(do_push) - FETCH_CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (wr_en) begin
        mem_q[wr_idx] <= push_data_i;
      end
    end
  end

  assign valid_o = (cnt_q != '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/rv32_fetch_stage.sv
// RV32 instruction fetch: PC sequencing, single-outstanding memory requests, redirect and
// misaligned-target handling in front of a small instruction buffer.
module rv32_fetch_stage
  import rv32_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         pend_q, pend_d;  // request driven but not yet accepted
  logic         out_q, out_d;    // request accepted, response not yet seen
  logic         drop_q, drop_d;  // the in-flight request belongs to a redirected-away stream

  logic                   can_issue, req_fire, rsp_hit, misaligned;
  logic                   buf_push, buf_pop, buf_valid;
  fetch_entry_t           buf_in, buf_head;
  logic [FETCH_CNT_W-1:0] buf_count;

  assign misaligned = (redirect_target[1:0] != 2'b00);
  assign can_issue  = (state_q == S_REQ) && !pend_q && !out_q && !drop_q &&
                      (32'(buf_count) < FETCH_BUF_DEPTH);

  assign imem_req_valid = !rst && (pend_q || can_issue);
  assign imem_req_addr  = pend_q ? addr_q : {pc_q[31:2], 2'b00};
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_hit        = imem_rsp_valid && out_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = imem_req_valid ? imem_req_addr : addr_q;
    pend_d   = imem_req_valid && !imem_req_ready;
    out_d    = req_fire || (out_q && !imem_rsp_valid);
    // Stale-ness sticks to whatever request is still in the channel after this cycle.
    drop_d   = (redirect_valid || drop_q) && (pend_d || out_d);
    buf_push = 1'b0;
    buf_in   = '0;
    if (redirect_valid) begin
      pc_d = redirect_target;
      if (misaligned) begin
        state_d  = S_FAULT;
        buf_push = 1'b1;
        buf_in   = '{pc: redirect_target, instr: NOP_INSTR, fault: 1'b1};
      end else begin
        state_d = S_REQ;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire && !drop_q) begin
            state_d = S_WAIT;
            pc_d    = next_pc(pc_q);
          end
        end
        S_WAIT: begin
          if (rsp_hit) begin
            state_d  = S_REQ;
            buf_push = 1'b1;
            buf_in   = '{pc: addr_q, instr: imem_rsp_data, fault: 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      pend_q  <= 1'b0;
      out_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
    end
  end

  assign buf_pop = if_valid && if_ready;

  rv32_fetch_buf u_buf (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (redirect_valid),
    .push_i      (buf_push),
    .push_data_i (buf_in),
    .pop_i       (buf_pop),
    .valid_o     (buf_valid),
    .head_o      (buf_head),
    .count_o     (buf_count)
  );

  assign if_valid = buf_valid && !rst;
  assign if_pc    = if_valid ? buf_head.pc    : '0;
  assign if_instr = if_valid ? buf_head.instr : '0;
  assign if_fault = if_valid && buf_head.fault;

endmodule
